// File: rtl/store_buffer_mq_if.sv
// Store-buffer port bundle: LSU store/commit/alias side plus the data-cache write port.
// master = LSU and cache environment, slave = store_buffer_mq.
interface store_buffer_mq_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PLEN = 56
);
  localparam int unsigned BEW = XLEN / 8;

  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  logic [PLEN-1:0] paddr_i;
  logic [XLEN-1:0] data_i;
  logic [BEW-1:0]  be_i;
  logic [1:0]      size_i;
  logic            commit_i;
  logic            commit_ready_o;
  logic [11:0]     page_offset_i;
  logic            page_offset_matches_o;
  logic            no_st_pending_o;
  logic            empty_o;
  logic            mem_req_o;
  logic            mem_gnt_i;
  logic [PLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_data_o;
  logic [BEW-1:0]  mem_be_o;
  logic [1:0]      mem_size_o;

  modport master (
    output flush_i, valid_i, paddr_i, data_i, be_i, size_i, commit_i, page_offset_i, mem_gnt_i,
    input  ready_o, commit_ready_o, page_offset_matches_o, no_st_pending_o, empty_o,
           mem_req_o, mem_addr_o, mem_data_o, mem_be_o, mem_size_o
  );

  modport slave (
    input  flush_i, valid_i, paddr_i, data_i, be_i, size_i, commit_i, page_offset_i, mem_gnt_i,
    output ready_o, commit_ready_o, page_offset_matches_o, no_st_pending_o, empty_o,
           mem_req_o, mem_addr_o, mem_data_o, mem_be_o, mem_size_o
  );
endinterface

// File: rtl/store_buffer_mq.sv
// Two-stage store buffer: speculative queue -> commit queue -> data-cache drain.
// Define STORE_BUFFER_COALESCE_EN to merge committed stores into a same-doubleword commit tail.
module store_buffer_mq #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned PLEN         = 56,
  parameter int unsigned SPEC_DEPTH   = 4,
  parameter int unsigned COMMIT_DEPTH = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  store_buffer_mq_if.slave sb
);

  localparam int unsigned BEW = XLEN / 8;
  localparam int unsigned SAW = $clog2(SPEC_DEPTH);
  localparam int unsigned CAW = $clog2(COMMIT_DEPTH);
  localparam logic [SAW:0] SPEC_FULL   = (SAW+1)'(SPEC_DEPTH);
  localparam logic [CAW:0] COMMIT_FULL = (CAW+1)'(COMMIT_DEPTH);

  typedef struct packed {
    logic [PLEN-1:0] paddr;
    logic [XLEN-1:0] data;
    logic [BEW-1:0]  be;
    logic [1:0]      size;
  } entry_t;

  entry_t         spec_q [SPEC_DEPTH];
  entry_t         com_q  [COMMIT_DEPTH];
  logic [SAW-1:0] spec_rptr, spec_wptr, spec_off;
  logic [SAW:0]   spec_cnt;
  logic [CAW-1:0] com_rptr, com_wptr, com_off;
  logic [CAW:0]   com_cnt;

  logic   push, do_commit, pop_mem, merge;
  entry_t new_entry, spec_head, com_head;

  assign new_entry = '{paddr: sb.paddr_i, data: sb.data_i, be: sb.be_i, size: sb.size_i};
  assign spec_head = spec_q[spec_rptr];
  assign com_head  = com_q[com_rptr];

  // Handshake status is a function of registered occupancy only
  assign sb.ready_o         = (spec_cnt != SPEC_FULL);
  assign sb.commit_ready_o  = (spec_cnt != '0) && (com_cnt != COMMIT_FULL);
  assign sb.mem_req_o       = (com_cnt != '0);
  assign sb.no_st_pending_o = (com_cnt == '0);
  assign sb.empty_o         = (spec_cnt == '0) && (com_cnt == '0);

  assign push      = sb.valid_i && sb.ready_o && !sb.flush_i;
  assign do_commit = sb.commit_i && sb.commit_ready_o;
  assign pop_mem   = sb.mem_req_o && sb.mem_gnt_i;

  assign sb.mem_addr_o = sb.mem_req_o ? com_head.paddr : '0;
  assign sb.mem_data_o = sb.mem_req_o ? com_head.data  : '0;
  assign sb.mem_be_o   = sb.mem_req_o ? com_head.be    : '0;
  assign sb.mem_size_o = sb.mem_req_o ? com_head.size  : '0;

`ifdef STORE_BUFFER_COALESCE_EN
  logic [CAW-1:0] com_tail_ptr;
  entry_t         com_tail, merged;

  assign com_tail_ptr = CAW'(com_wptr - CAW'(1));
  assign com_tail     = com_q[com_tail_ptr];
  // Tail must differ from the head, which may be on the bus right now
  assign merge = do_commit && (com_cnt >= (CAW+1)'(2)) &&
                 (com_tail.paddr[PLEN-1:3] == spec_head.paddr[PLEN-1:3]);

  always_comb begin
    merged      = com_tail;
    merged.be   = com_tail.be | spec_head.be;
    merged.size = 2'd3;
    for (int b = 0; b < int'(BEW); b++) begin
      if (spec_head.be[b]) merged.data[8*b +: 8] = spec_head.data[8*b +: 8];
    end
  end
`else
  assign merge = 1'b0;
`endif

  // Occupancy and pointers; flush acts after the same-cycle commit has been taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_rptr <= '0;
      spec_wptr <= '0;
      spec_cnt  <= '0;
      com_rptr  <= '0;
      com_wptr  <= '0;
      com_cnt   <= '0;
    end else begin
      if (sb.flush_i) begin
        spec_rptr <= '0;
        spec_wptr <= '0;
        spec_cnt  <= '0;
      end else begin
        if (push)      spec_wptr <= SAW'(spec_wptr + SAW'(1));
        if (do_commit) spec_rptr <= SAW'(spec_rptr + SAW'(1));
        spec_cnt <= (SAW+1)'(spec_cnt + (SAW+1)'(push) - (SAW+1)'(do_commit));
      end
      if (do_commit && !merge) com_wptr <= CAW'(com_wptr + CAW'(1));
      if (pop_mem)             com_rptr <= CAW'(com_rptr + CAW'(1));
      com_cnt <= (CAW+1)'(com_cnt + (CAW+1)'(do_commit && !merge) - (CAW+1)'(pop_mem));
    end
  end

  // Payload storage carries no reset; validity comes from the counters
  always_ff @(posedge clk_i) begin
    if (push) spec_q[spec_wptr] <= new_entry;
`ifdef STORE_BUFFER_COALESCE_EN
    if (do_commit && merge) com_q[com_tail_ptr] <= merged;
`endif
    if (do_commit && !merge) com_q[com_wptr] <= spec_head;
  end

  // Load aliasing on doubleword index across all live entries and the incoming store
  always_comb begin
    sb.page_offset_matches_o = sb.valid_i && (sb.paddr_i[11:3] == sb.page_offset_i[11:3]);
    spec_off = '0;
    com_off  = '0;
    for (int i = 0; i < int'(SPEC_DEPTH); i++) begin
      spec_off = SAW'(SAW'(i) - spec_rptr);
      if (({1'b0, spec_off} < spec_cnt) && (spec_q[i].paddr[11:3] == sb.page_offset_i[11:3]))
        sb.page_offset_matches_o = 1'b1;
    end
    for (int i = 0; i < int'(COMMIT_DEPTH); i++) begin
      com_off = CAW'(CAW'(i) - com_rptr);
      if (({1'b0, com_off} < com_cnt) && (com_q[i].paddr[11:3] == sb.page_offset_i[11:3]))
        sb.page_offset_matches_o = 1'b1;
    end
  end

  // A commit is only legal when the buffer advertised it can take one
  commit_protocol_a : assert property (@(posedge clk_i) disable iff (rst_i)
    sb.commit_i |-> sb.commit_ready_o);

endmodule
